// File: rtl/bus_mem_slave.sv
// bus_mem_slave: memory-mapped responder for the shared system bus.
// Decodes an address window, holds a word-addressed RAM of 2^ADDR_BITS words,
// waits WAIT_STATES cycles, then acknowledges on the tri-state ready/data lines.
// Optional feature macro: BUS_SLAVE_WP_EN (adds the wp write-protect input).
module bus_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  inout  wire  [31:0] data,
  input  logic        request,
  input  logic        r_w,
  inout  wire         ready,
`ifdef BUS_SLAVE_WP_EN
  input  logic        wp,
`endif
  output logic        busy
);

  localparam int unsigned TAG_LSB = ADDR_BITS + 2;
  localparam int unsigned DEPTH   = 1 << ADDR_BITS;
  // The counter is loaded with WAIT_STATES-1 so that ACK is entered on the
  // WAIT_STATES-th edge after the hit-sampling edge.
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 busy_q;
  logic                 rd_q;
  logic [31:0]          rdata_q;
  logic                 hit;
  logic                 ack_enter;
  logic                 wr_block;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] index;
  logic                 unused_byte_lanes;

  // Word RAM; deliberately not reset so it maps onto block RAM.
  logic [31:0] mem [DEPTH];

  // Only whole words are transferred, so the byte-lane bits carry no meaning.
  assign unused_byte_lanes = ^address[1:0];

  assign hit   = request && (address[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign index = address[TAG_LSB-1:2];

`ifdef BUS_SLAVE_WP_EN
  assign wr_block = wp;
`else
  assign wr_block = 1'b0;
`endif

  // Next-state logic: IDLE -> (WAIT ->) ACK on a hit, abort from WAIT when request drops.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_enter = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          if (WAIT_STATES == 0) begin
            state_d   = S_ACK;
            ack_enter = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!request) begin
          // Abort: the master gave up before we answered, nothing is committed.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d   = S_ACK;
          ack_enter = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        if (!request) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, registered busy and the direction of the transfer being acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != S_IDLE);
      if (ack_enter) begin
        rd_q <= r_w;
      end
    end
  end

  // A write commits on the ACK-entry edge; reset held low on that edge wins.
  assign mem_we = ack_enter && !r_w && !wr_block && rst_n;

  // RAM write port and registered read, both on the ACK-entry edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[index] <= data;
    end
    if (ack_enter) begin
      rdata_q <= mem[index];
    end
  end

  assign busy  = busy_q;
  // The slave only ever pulls ready high; every other master/slave sees z.
  assign ready = (state_q == S_ACK) ? 1'b1 : 1'bz;
  assign data  = ((state_q == S_ACK) && rd_q) ? rdata_q : 32'bz;

endmodule
